inst_sram_port_arbiter: RTL and testbench

//   Shares the single instruction-SRAM port (OBI-style req/gnt/rvalid) between two requesters:

---
 rtl/inst_sram_port_arbiter_if.sv | 25 ++
 rtl/inst_sram_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_inst_sram_port_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_sram_port_arbiter_if.sv
// One OBI-style request/response link (req/gnt + rvalid), used for both requesters and the SRAM.
// The master drives the request fields; the slave drives grant and response.
interface inst_sram_port_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                    req;
   logic                    gnt;
   logic [ADDR_WIDTH-1:0]   addr;
   logic                    we;
   logic [DATA_WIDTH/8-1:0] be;
   logic [DATA_WIDTH-1:0]   wdata;
   logic                    rvalid;
   logic [DATA_WIDTH-1:0]   rdata;

   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/inst_sram_port_arbiter.sv
// Two-to-one arbiter for the instruction-SRAM port: core fetch (port 0) has priority, the AXI
// adapter (port 1) is forced after a run of port-0 grants, and responses are routed by owner.
module inst_sram_port_arbiter #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned STARVE_LIMIT    = 4
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   inst_sram_port_arbiter_if.slave  p0,
   inst_sram_port_arbiter_if.slave  p1,
   inst_sram_port_arbiter_if.master mem,
   output logic                   busy_o,
   output logic                   err_o
);

   localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

   // owner_q[0] is the head; entries shift down on every response.
   logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
   logic [CntW-1:0]            count_q, count_d;
   logic                       lock_vld_q, lock_vld_d;
   logic                       lock_owner_q, lock_owner_d;
   logic [StW-1:0]             starve_q, starve_d;
   logic                       err_q, err_d;

   logic                    sel_vld, sel_port, sel_req;
   logic                    fifo_full, fifo_empty, hs, pop;
   logic [CntW-1:0]         wr_idx;
   logic [ADDR_WIDTH-1:0]   addr_sel;
   logic                    we_sel;
   logic [DATA_WIDTH/8-1:0] be_sel;
   logic [DATA_WIDTH-1:0]   wdata_sel;

   assign fifo_full  = (count_q == CntW'(MAX_OUTSTANDING));
   assign fifo_empty = (count_q == '0);

   always_comb begin
      sel_vld  = 1'b0;
      sel_port = 1'b0;
      if (lock_vld_q) begin
         sel_vld  = 1'b1;
         sel_port = lock_owner_q;
      end else if (p1.req && (starve_q == StW'(STARVE_LIMIT))) begin
         sel_vld  = 1'b1;
         sel_port = 1'b1;
      end else if (p0.req) begin
         sel_vld  = 1'b1;
         sel_port = 1'b0;
      end else if (p1.req) begin
         sel_vld  = 1'b1;
         sel_port = 1'b1;
      end
   end

   always_comb begin
      addr_sel  = '0;
      we_sel    = 1'b0;
      be_sel    = '0;
      wdata_sel = '0;
      if (sel_vld) begin
         if (sel_port) begin
            addr_sel  = p1.addr;
            we_sel    = p1.we;
            be_sel    = p1.be;
            wdata_sel = p1.wdata;
         end else begin
            addr_sel  = p0.addr;
            we_sel    = p0.we;
            be_sel    = p0.be;
            wdata_sel = p0.wdata;
         end
      end
   end

   assign sel_req   = sel_vld & (sel_port ? p1.req : p0.req);
   assign mem.req   = sel_req & ~fifo_full;
   assign mem.addr  = addr_sel;
   assign mem.we    = we_sel;
   assign mem.be    = be_sel;
   assign mem.wdata = wdata_sel;

   assign hs  = mem.req & mem.gnt;
   assign pop = mem.rvalid & ~fifo_empty;

   assign p0.gnt    = hs & ~sel_port;
   assign p1.gnt    = hs & sel_port;
   assign p0.rvalid = pop & ~owner_q[0];
   assign p1.rvalid = pop & owner_q[0];
   assign p0.rdata  = mem.rdata;
   assign p1.rdata  = mem.rdata;

   assign busy_o = mem.req | ~fifo_empty;
   assign err_o  = err_q;

   // A simultaneous pop frees the slot below the current tail before the push lands.
   assign wr_idx = count_q - CntW'(pop);

   always_comb begin
      owner_d = pop ? (owner_q >> 1) : owner_q;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
         if (hs && (CntW'(i) == wr_idx)) owner_d[i] = sel_port;
      end
      count_d = count_q + CntW'(hs) - CntW'(pop);

      // Holding the lock only while a request is pending keeps OBI fields stable until granted.
      lock_vld_d   = mem.req & ~mem.gnt;
      lock_owner_d = sel_port;

      starve_d = starve_q;
      if (!p1.req || (hs && sel_port)) begin
         starve_d = '0;
      end else if (hs && (starve_q != StW'(STARVE_LIMIT))) begin
         starve_d = starve_q + StW'(1);
      end

      err_d = err_q | (mem.rvalid & fifo_empty);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         owner_q      <= '0;
         count_q      <= '0;
         lock_vld_q   <= 1'b0;
         lock_owner_q <= 1'b0;
         starve_q     <= '0;
         err_q        <= 1'b0;
      end else begin
         owner_q      <= owner_d;
         count_q      <= count_d;
         lock_vld_q   <= lock_vld_d;
         lock_owner_q <= lock_owner_d;
         starve_q     <= starve_d;
         err_q        <= err_d;
      end
   end

endmodule

// File: tb/tb_inst_sram_port_arbiter.sv
// Randomized bench: two OBI requesters and an SRAM responder driven from $urandom, checked each
// cycle against a queue-based reference of the arbitration and response-routing rules.
module tb_inst_sram_port_arbiter;

   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int unsigned BW   = DW / 8;
   localparam int unsigned MAXO = 2;
   localparam int unsigned LIM  = 4;

   logic clk = 1'b0;
   logic reset;
   logic busy, err;

   always #5 clk = ~clk;

   inst_sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p0_bus ();
   inst_sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p1_bus ();
   inst_sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

   inst_sram_port_arbiter #(
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW),
      .MAX_OUTSTANDING (MAXO),
      .STARVE_LIMIT    (LIM)
   ) u_dut (
      .clk_i   (clk),
      .reset_i (reset),
      .p0      (p0_bus.slave),
      .p1      (p1_bus.slave),
      .mem     (mem_bus.master),
      .busy_o  (busy),
      .err_o   (err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: owners of accepted transactions in order, SRAM pending responses.
   int             own_q[$];
   logic [DW-1:0]  resp_q[$];
   bit             pend_v;
   int             pend_o;
   int             starve;
   bit             err_m;

   bit             rq[2];
   logic [AW-1:0]  ra[2];
   bit             rwe[2];
   logic [BW-1:0]  rbe[2];
   logic [DW-1:0]  rwd[2];
   int             p_req[2];
   int             p_gnt;
   int             p_rv;
   bit             force_rv;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drive_bus(input bit gnt, input bit rv, input logic [DW-1:0] rd);
      p0_bus.req     = rq[0];
      p0_bus.addr    = ra[0];
      p0_bus.we      = rwe[0];
      p0_bus.be      = rbe[0];
      p0_bus.wdata   = rwd[0];
      p1_bus.req     = rq[1];
      p1_bus.addr    = ra[1];
      p1_bus.we      = rwe[1];
      p1_bus.be      = rbe[1];
      p1_bus.wdata   = rwd[1];
      mem_bus.gnt    = gnt;
      mem_bus.rvalid = rv;
      mem_bus.rdata  = rd;
   endtask

   task automatic model_clear();
      own_q.delete();
      resp_q.delete();
      pend_v = 1'b0;
      pend_o = 0;
      starve = 0;
      err_m  = 1'b0;
   endtask

   task automatic step(input bit chk);
      bit            gnt, rv, hs, e_req, sel_req;
      int            sel;
      logic [DW-1:0] rd;
      logic [AW-1:0] e_addr;
      bit            e_we;
      logic [BW-1:0] e_be;
      logic [DW-1:0] e_wd;

      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
         if (!rq[p] && int'($urandom_range(99)) < p_req[p]) begin
            rq[p]  = 1'b1;
            ra[p]  = $urandom;
            rwe[p] = 1'($urandom_range(1));
            rbe[p] = BW'($urandom);
            rwd[p] = $urandom;
         end
      end
      gnt = int'($urandom_range(99)) < p_gnt;
      rv  = force_rv || (resp_q.size() > 0 && int'($urandom_range(99)) < p_rv);
      rd  = (resp_q.size() > 0) ? resp_q[0] : $urandom;
      drive_bus(gnt, rv, rd);
      #1;

      // Pending (ungranted) request keeps its owner; otherwise priority with starvation escape.
      sel = -1;
      if (pend_v) sel = pend_o;
      else if (rq[1] && starve == LIM) sel = 1;
      else if (rq[0]) sel = 0;
      else if (rq[1]) sel = 1;

      sel_req = 1'b0;
      e_addr = '0; e_we = 1'b0; e_be = '0; e_wd = '0;
      if (sel >= 0) begin
         sel_req = rq[sel];
         e_addr = ra[sel]; e_we = rwe[sel]; e_be = rbe[sel]; e_wd = rwd[sel];
      end
      e_req = sel_req && (own_q.size() < MAXO);
      hs    = e_req && gnt;

      if (chk) begin
         check("mem_req", 64'(mem_bus.req), 64'(e_req));
         check("p0_gnt", 64'(p0_bus.gnt), 64'(hs && sel == 0));
         check("p1_gnt", 64'(p1_bus.gnt), 64'(hs && sel == 1));
         check("mem_addr", 64'(mem_bus.addr), 64'(e_addr));
         check("mem_we", 64'(mem_bus.we), 64'(e_we));
         check("mem_be", 64'(mem_bus.be), 64'(e_be));
         check("mem_wdata", 64'(mem_bus.wdata), 64'(e_wd));
         check("p0_rvalid", 64'(p0_bus.rvalid), 64'(rv && own_q.size() > 0 && own_q[0] == 0));
         check("p1_rvalid", 64'(p1_bus.rvalid), 64'(rv && own_q.size() > 0 && own_q[0] == 1));
         if (rv) begin
            check("p0_rdata", 64'(p0_bus.rdata), 64'(rd));
            check("p1_rdata", 64'(p1_bus.rdata), 64'(rd));
         end
         check("busy", 64'(busy), 64'(e_req || own_q.size() > 0));
         check("err", 64'(err), 64'(err_m));
      end

      if (rv) begin
         if (own_q.size() > 0) void'(own_q.pop_front());
         else err_m = 1'b1;
         if (resp_q.size() > 0) void'(resp_q.pop_front());
      end
      if (!rq[1] || (hs && sel == 1)) starve = 0;
      else if (hs && sel == 0 && starve < LIM) starve++;
      pend_v = e_req && !gnt;
      pend_o = sel;
      if (hs) begin
         own_q.push_back(sel);
         resp_q.push_back($urandom);
         rq[sel] = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      rq[0]    = 1'b0;
      rq[1]    = 1'b0;
      force_rv = 1'b0;
      drive_bus(1'b0, 1'b0, '0);
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      #1;
      check("rst_mem_req", 64'(mem_bus.req), 64'd0);
      check("rst_gnt", 64'({p0_bus.gnt, p1_bus.gnt}), 64'd0);
      check("rst_rvalid", 64'({p0_bus.rvalid, p1_bus.rvalid}), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err), 64'd0);
   endtask

   // {p0 req %, p1 req %, gnt %, rvalid %} per phase.
   int tbl[8][4] = '{
      '{100, 100, 100, 100},
      '{100,   0, 100, 100},
      '{100, 100,  30, 100},
      '{100, 100, 100,   0},
      '{ 60,  60,  70,  30},
      '{  0, 100, 100, 100},
      '{100, 100,  60,  60},
      '{ 30,  30,  40,  50}
   };

   initial begin
      reset    = 1'b1;
      force_rv = 1'b0;
      rq[0]    = 1'b0;
      rq[1]    = 1'b0;
      ra[0] = '0; ra[1] = '0; rwe[0] = 1'b0; rwe[1] = 1'b0;
      rbe[0] = '0; rbe[1] = '0; rwd[0] = '0; rwd[1] = '0;
      drive_bus(1'b0, 1'b0, '0);
      repeat (2) @(negedge clk);
      do_reset();

      for (int ph = 0; ph < 8; ph++) begin
         p_req[0] = tbl[ph][0];
         p_req[1] = tbl[ph][1];
         p_gnt    = tbl[ph][2];
         p_rv     = tbl[ph][3];
         repeat (150) step(1'b1);
         if (ph == 3 || ph == 6) do_reset();
      end

      // Spurious response with nothing outstanding: dropped, error sticks until reset.
      do_reset();
      p_req[0] = 0; p_req[1] = 0; p_gnt = 100; p_rv = 0;
      force_rv = 1'b1;
      step(1'b1);
      force_rv = 1'b0;
      p_req[0] = 50; p_req[1] = 50; p_rv = 50;
      repeat (20) step(1'b1);
      check("err_sticky", 64'(err), 64'd1);
      do_reset();
      repeat (10) step(1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
